// File: rtl/reg_y_ctx_pkg.sv
// Shared definitions for the Y operand register: op codes and stack request decode.
package reg_y_ctx_pkg;

  localparam logic [2:0] REG_Y_OP_HOLD = 3'b000;
  localparam logic [2:0] REG_Y_OP_LOAD = 3'b001;
  localparam logic [2:0] REG_Y_OP_CLR  = 3'b010;
  localparam logic [2:0] REG_Y_OP_INC  = 3'b011;
  localparam logic [2:0] REG_Y_OP_DEC  = 3'b100;
  localparam logic [2:0] REG_Y_OP_SHL  = 3'b101;
  localparam logic [2:0] REG_Y_OP_SHR  = 3'b110;
  localparam logic [2:0] REG_Y_OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    STK_IDLE,
    STK_PUSH,
    STK_POP,
    STK_CONFLICT
  } stk_req_e;

  function automatic stk_req_e decode_req(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return STK_PUSH;
      2'b01:   return STK_POP;
      2'b11:   return STK_CONFLICT;
      default: return STK_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/reg_y_ctx_stack.sv
// DEPTH-entry LIFO shadow stack for Y; flags overflow/underflow as single-cycle pulses.
module reg_y_ctx_stack #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             reg_y_clk,
  input  logic             reg_y_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [PTR_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign top_ptr = depth - PTR_W'(1);
  assign wr_idx  = depth[IDX_W-1:0];
  assign rd_idx  = top_ptr[IDX_W-1:0];

  assign full    = (depth == PTR_W'(DEPTH));
  assign empty   = (depth == '0);
  assign rd_data = mem[rd_idx];
  assign ovf     = push & ~pop & full;
  assign unf     = pop & ~push & empty;

  always_ff @(posedge reg_y_clk or posedge reg_y_rst) begin
    if (reg_y_rst) begin
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !pop && !full) begin
      mem[wr_idx] <= wr_data;
      depth       <= depth + PTR_W'(1);
    end else if (pop && !push && !empty) begin
      depth <= top_ptr;
    end
  end

endmodule

// File: rtl/reg_y_ctx.sv
// Y operand register with in-place ALU ops, carry/zero status and a shadow context stack.
module reg_y_ctx
  import reg_y_ctx_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             reg_y_clk,
  input  logic             reg_y_rst,
  input  logic [WIDTH-1:0] reg_y_in,
  input  logic             reg_y_en,
  input  logic [2:0]       reg_y_op,
  input  logic             reg_y_push,
  input  logic             reg_y_pop,
  input  logic             reg_y_err_clr,
  output logic [WIDTH-1:0] reg_y_out,
  output logic             reg_y_zero,
  output logic             reg_y_carry,
  output logic [PTR_W-1:0] reg_y_depth,
  output logic             reg_y_full,
  output logic             reg_y_empty,
  output logic             reg_y_err
);

  stk_req_e         req;
  logic             stk_push;
  logic             stk_pop;
  logic             stk_ovf;
  logic             stk_unf;
  logic             conflict;
  logic             do_pop;
  logic [WIDTH-1:0] stk_top;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             err;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  assign req      = decode_req(reg_y_push, reg_y_pop);
  assign stk_push = (req == STK_PUSH);
  assign stk_pop  = (req == STK_POP);
  assign conflict = (req == STK_CONFLICT);
  // A successful pop restores Y and overrides any op requested in the same cycle.
  assign do_pop   = stk_pop & ~reg_y_empty;

  reg_y_ctx_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .reg_y_clk (reg_y_clk),
    .reg_y_rst (reg_y_rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .wr_data   (y),
    .rd_data   (stk_top),
    .depth     (reg_y_depth),
    .full      (reg_y_full),
    .empty     (reg_y_empty),
    .ovf       (stk_ovf),
    .unf       (stk_unf)
  );

  always_comb begin
    alu_y = y;
    alu_c = carry;
    if (reg_y_en) begin
      case (reg_y_op)
        REG_Y_OP_LOAD: alu_y = reg_y_in;
        REG_Y_OP_CLR:  alu_y = '0;
        REG_Y_OP_INC:  {alu_c, alu_y} = {1'b0, y} + (WIDTH + 1)'(1);
        REG_Y_OP_DEC:  {alu_c, alu_y} = {1'b0, y} - (WIDTH + 1)'(1);
        REG_Y_OP_SHL: begin
          alu_c = y[WIDTH-1];
          alu_y = {y[WIDTH-2:0], 1'b0};
        end
        REG_Y_OP_SHR: begin
          alu_c = y[0];
          alu_y = {1'b0, y[WIDTH-1:1]};
        end
        REG_Y_OP_NOT:  alu_y = ~y;
        default:       alu_y = y;
      endcase
    end
  end

  always_ff @(posedge reg_y_clk or posedge reg_y_rst) begin
    if (reg_y_rst) begin
      y     <= '0;
      carry <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (do_pop) begin
        y <= stk_top;
      end else begin
        y     <= alu_y;
        carry <= alu_c;
      end
      // A fresh error outranks a clear request in the same cycle.
      if (stk_ovf || stk_unf || conflict) err <= 1'b1;
      else if (reg_y_err_clr)             err <= 1'b0;
    end
  end

  assign reg_y_out   = y;
  assign reg_y_zero  = (y == '0);
  assign reg_y_carry = carry;
  assign reg_y_err   = err;

endmodule

// File: tb/tb_reg_y_ctx.sv
// Scoreboard bench for reg_y_ctx: directed steps queue expected state, a monitor checks it.
module tb_reg_y_ctx;
  import reg_y_ctx_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             en = 1'b0;
  logic [2:0]       op = REG_Y_OP_HOLD;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic [PTR_W-1:0] depth;
  logic             full;
  logic             empty;
  logic             err;

  reg_y_ctx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .reg_y_clk     (clk),
    .reg_y_rst     (rst),
    .reg_y_in      (din),
    .reg_y_en      (en),
    .reg_y_op      (op),
    .reg_y_push    (push),
    .reg_y_pop     (pop),
    .reg_y_err_clr (err_clr),
    .reg_y_out     (out),
    .reg_y_zero    (zero),
    .reg_y_carry   (carry),
    .reg_y_depth   (depth),
    .reg_y_full    (full),
    .reg_y_empty   (empty),
    .reg_y_err     (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         id;
    logic [7:0] y;
    logic       c;
    logic [2:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic chk_state(input exp_t x);
    chk("out",   x.id, 32'(out),   32'(x.y));
    chk("zero",  x.id, 32'(zero),  32'(x.y == 8'h00));
    chk("carry", x.id, 32'(carry), 32'(x.c));
    chk("depth", x.id, 32'(depth), 32'(x.d));
    chk("full",  x.id, 32'(full),  32'(x.d == 3'd4));
    chk("empty", x.id, 32'(empty), 32'(x.d == 3'd0));
    chk("err",   x.id, 32'(err),   32'(x.e));
  endtask

  task automatic step(input logic e, input logic [2:0] o, input logic [7:0] d,
                      input logic pu, input logic po, input logic cl,
                      input logic [7:0] ey, input logic ec, input logic [2:0] ed, input logic ee);
    exp_t x;
    @(negedge clk);
    en = e; op = o; din = d; push = pu; pop = po; err_clr = cl;
    x.id = step_no; x.y = ey; x.c = ec; x.d = ed; x.e = ee;
    q.push_back(x);
    step_no++;
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0; op = REG_Y_OP_HOLD; din = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  // Monitor: each queued expectation belongs to the edge following its stimulus.
  initial begin
    forever begin
      exp_t x;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk_state(x);
      end
    end
  end

  initial begin
    exp_t rx;
    rx.id = 0; rx.y = 8'h00; rx.c = 1'b0; rx.d = 3'd0; rx.e = 1'b0;
    #12;
    chk_state(rx);
    @(negedge clk);
    rst = 1'b0;

    //    en  op             din    pu   po   cl    y      c    d    e
    step(1, REG_Y_OP_LOAD, 8'hFF, 0, 0, 0, 8'hFF, 0, 3'd0, 0);
    step(1, REG_Y_OP_INC,  8'h00, 0, 0, 0, 8'h00, 1, 3'd0, 0);
    step(1, REG_Y_OP_DEC,  8'h00, 0, 0, 0, 8'hFF, 1, 3'd0, 0);
    step(1, REG_Y_OP_DEC,  8'h00, 0, 0, 0, 8'hFE, 0, 3'd0, 0);
    step(1, REG_Y_OP_LOAD, 8'h81, 0, 0, 0, 8'h81, 0, 3'd0, 0);
    step(1, REG_Y_OP_SHL,  8'h00, 0, 0, 0, 8'h02, 1, 3'd0, 0);
    step(1, REG_Y_OP_SHR,  8'h00, 0, 0, 0, 8'h01, 0, 3'd0, 0);
    step(1, REG_Y_OP_SHR,  8'h00, 0, 0, 0, 8'h00, 1, 3'd0, 0);
    step(1, REG_Y_OP_NOT,  8'h00, 0, 0, 0, 8'hFF, 1, 3'd0, 0);
    step(1, REG_Y_OP_HOLD, 8'h33, 0, 0, 0, 8'hFF, 1, 3'd0, 0);
    step(1, REG_Y_OP_LOAD, 8'h11, 0, 0, 0, 8'h11, 1, 3'd0, 0);
    step(1, REG_Y_OP_LOAD, 8'h22, 1, 0, 0, 8'h22, 1, 3'd1, 0);
    step(1, REG_Y_OP_CLR,  8'h00, 0, 1, 0, 8'h11, 1, 3'd0, 0);
    // Fill the stack with 1..4, then overflow with 5 while an INC still executes.
    step(1, REG_Y_OP_LOAD, 8'h01, 0, 0, 0, 8'h01, 1, 3'd0, 0);
    step(1, REG_Y_OP_LOAD, 8'h02, 1, 0, 0, 8'h02, 1, 3'd1, 0);
    step(1, REG_Y_OP_LOAD, 8'h03, 1, 0, 0, 8'h03, 1, 3'd2, 0);
    step(1, REG_Y_OP_LOAD, 8'h04, 1, 0, 0, 8'h04, 1, 3'd3, 0);
    step(1, REG_Y_OP_LOAD, 8'h05, 1, 0, 0, 8'h05, 1, 3'd4, 0);
    step(1, REG_Y_OP_INC,  8'h00, 1, 0, 0, 8'h06, 0, 3'd4, 1);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 1, 0, 8'h04, 0, 3'd3, 1);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 1, 0, 8'h03, 0, 3'd2, 1);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 1, 0, 8'h02, 0, 3'd1, 1);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 1, 0, 8'h01, 0, 3'd0, 1);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 1, 0, 8'h01, 0, 3'd0, 1);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 0, 1, 8'h01, 0, 3'd0, 0);
    // Conflicting push+pop at depth 2, error clear, and set-wins on empty pop.
    step(0, REG_Y_OP_INC,  8'h00, 1, 0, 0, 8'h01, 0, 3'd1, 0);
    step(1, REG_Y_OP_LOAD, 8'h07, 1, 0, 0, 8'h07, 0, 3'd2, 0);
    step(1, REG_Y_OP_INC,  8'h00, 1, 1, 0, 8'h08, 0, 3'd2, 1);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 0, 1, 8'h08, 0, 3'd2, 0);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 1, 0, 8'h01, 0, 3'd1, 0);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 1, 0, 8'h01, 0, 3'd0, 0);
    step(1, REG_Y_OP_INC,  8'h00, 0, 1, 1, 8'h02, 0, 3'd0, 1);
    // Build depth 3 with Y=5A and carry set before an asynchronous reset.
    step(1, REG_Y_OP_LOAD, 8'h00, 0, 0, 0, 8'h00, 0, 3'd0, 1);
    step(1, REG_Y_OP_DEC,  8'h00, 0, 0, 0, 8'hFF, 1, 3'd0, 1);
    step(1, REG_Y_OP_LOAD, 8'h5A, 1, 0, 0, 8'h5A, 1, 3'd1, 1);
    step(0, REG_Y_OP_HOLD, 8'h00, 1, 0, 0, 8'h5A, 1, 3'd2, 1);
    step(0, REG_Y_OP_HOLD, 8'h00, 1, 0, 0, 8'h5A, 1, 3'd3, 1);
    idle();
    #2;
    rst = 1'b1;
    #1;
    rx.id = 100;
    chk_state(rx);
    @(negedge clk);
    rst = 1'b0;
    step(1, REG_Y_OP_LOAD, 8'h03, 0, 0, 0, 8'h03, 0, 3'd0, 0);
    step(0, REG_Y_OP_HOLD, 8'h00, 0, 1, 0, 8'h03, 0, 3'd0, 1);
    idle();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
